// File: rtl/cdr_ctrl_pkg.sv
// Shared types and default gear constants for the CDR acquisition/tracking sequencer.
package cdr_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACQ    = 3'd1,
    ST_TRACK  = 3'd2,
    ST_LOCKED = 3'd3,
    ST_CLEAR  = 3'd4
  } cdr_state_e;

  typedef struct packed {
    logic [4:0] kp;
    logic [4:0] ki;
  } gear_t;

  localparam int unsigned ACQ_KP_DEF = 8;
  localparam int unsigned ACQ_KI_DEF = 14;
  localparam int unsigned TRK_KP_DEF = 12;
  localparam int unsigned TRK_KI_DEF = 18;

  function automatic gear_t make_gear(input int unsigned kp, input int unsigned ki);
    gear_t g;
    g.kp = 5'(kp);
    g.ki = 5'(ki);
    return g;
  endfunction

endpackage

// File: rtl/cdr_loop_sequencer_if.sv
// Strobe/error inputs and loop-filter control outputs between cdr_core and the sequencer.
interface cdr_loop_sequencer_if #(
  parameter int unsigned WIN_LOG2 = 6
);
  logic                     enable;
  logic                     sample_en;
  logic signed [15:0]       f_n;
  logic [4:0]               kp_shift;
  logic [4:0]               ki_shift;
  logic                     lf_clear;
  logic                     locked;
  logic [2:0]               state;
  logic [15+WIN_LOG2:0]     win_metric;

  modport master (
    output enable, sample_en, f_n,
    input  kp_shift, ki_shift, lf_clear, locked, state, win_metric
  );

  modport slave (
    input  enable, sample_en, f_n,
    output kp_shift, ki_shift, lf_clear, locked, state, win_metric
  );
endinterface

// File: rtl/cdr_err_window.sv
// Windowed |f_n| energy: accumulates 2^WIN_LOG2 strobes, pulses win_done and latches the sum.
module cdr_err_window #(
  parameter int unsigned WIN_LOG2 = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   sample_en,
  input  logic signed [15:0]     f_n,
  output logic                   win_done,
  output logic [15+WIN_LOG2:0]   win_sum,
  output logic [15+WIN_LOG2:0]   win_metric
);
  localparam int unsigned ACC_W = 16 + WIN_LOG2;

  logic [ACC_W-1:0]    acc;
  logic [WIN_LOG2-1:0] cnt;
  logic signed [16:0]  f_ext;
  logic [16:0]         mag;

  // One extra bit so |-32768| is representable without saturation.
  assign f_ext    = {f_n[15], f_n};
  assign mag      = f_ext[16] ? 17'(-f_ext) : 17'(f_ext);
  assign win_sum  = acc + ACC_W'(mag);
  assign win_done = sample_en && (cnt == '1);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc        <= '0;
      cnt        <= '0;
      win_metric <= '0;
    end else begin
      if (win_done) win_metric <= win_sum;
      if (clear || win_done) begin
        acc <= '0;
        cnt <= '0;
      end else if (sample_en) begin
        acc <= win_sum;
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdr_loop_sequencer.sv
// Gear-shift and lock sequencer for the CDR PI loop filter, driven by windowed PD error energy.
module cdr_loop_sequencer
  import cdr_ctrl_pkg::*;
#(
  parameter int unsigned WIN_LOG2         = 6,
  parameter int unsigned LOCK_THR         = 2048,
  parameter int unsigned UNLOCK_THR       = 4096,
  parameter int unsigned LOCK_WINS        = 4,
  parameter int unsigned LOSS_WINS        = 2,
  parameter int unsigned ACQ_TIMEOUT_WINS = 64,
  parameter int unsigned ACQ_KP_SHIFT     = ACQ_KP_DEF,
  parameter int unsigned ACQ_KI_SHIFT     = ACQ_KI_DEF,
  parameter int unsigned TRK_KP_SHIFT     = TRK_KP_DEF,
  parameter int unsigned TRK_KI_SHIFT     = TRK_KI_DEF
) (
  input logic                 clk,
  input logic                 rst,
  cdr_loop_sequencer_if.slave bus
);
  localparam int unsigned ACC_W  = 16 + WIN_LOG2;
  localparam int unsigned GOOD_W = $clog2(LOCK_WINS + 1);
  localparam int unsigned BAD_W  = $clog2(LOSS_WINS + 1);
  localparam int unsigned WIN_W  = $clog2(ACQ_TIMEOUT_WINS + 1);

  localparam logic [ACC_W-1:0] LOCK_THR_V   = ACC_W'(LOCK_THR);
  localparam logic [ACC_W-1:0] UNLOCK_THR_V = ACC_W'(UNLOCK_THR);
  localparam gear_t ACQ_GEAR = make_gear(ACQ_KP_SHIFT, ACQ_KI_SHIFT);
  localparam gear_t TRK_GEAR = make_gear(TRK_KP_SHIFT, TRK_KI_SHIFT);

  cdr_state_e        state_q, state_d;
  logic [GOOD_W-1:0] good_q, good_d;
  logic [BAD_W-1:0]  bad_q, bad_d;
  logic [WIN_W-1:0]  win_q, win_d;
  logic              active, win_done, win_good, win_bad, win_clear;
  logic [ACC_W-1:0]  win_sum, win_metric;
  gear_t             gear;

  assign active    = (state_q == ST_ACQ) || (state_q == ST_TRACK) || (state_q == ST_LOCKED);
  assign win_good  = win_sum < LOCK_THR_V;
  assign win_bad   = win_sum > UNLOCK_THR_V;
  // Any state change restarts the window so each state judges only its own samples.
  assign win_clear = (state_d != state_q) || !active;

  cdr_err_window #(.WIN_LOG2(WIN_LOG2)) u_window (
    .clk        (clk),
    .rst        (rst),
    .clear      (win_clear),
    .sample_en  (bus.sample_en && active),
    .f_n        (bus.f_n),
    .win_done   (win_done),
    .win_sum    (win_sum),
    .win_metric (win_metric)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      good_q  <= '0;
      bad_q   <= '0;
      win_q   <= '0;
    end else begin
      state_q <= state_d;
      good_q  <= good_d;
      bad_q   <= bad_d;
      win_q   <= win_d;
    end
  end

  // NOTE: every variable gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    bad_d   = bad_q;
    win_d   = win_q;
    unique case (state_q)
      ST_IDLE: if (bus.enable) state_d = ST_ACQ;
      ST_ACQ: if (win_done) begin
        good_d = win_good ? good_q + 1'b1 : '0;
        win_d  = win_q + 1'b1;
        // Advancing beats a coincident timeout.
        if (good_d == GOOD_W'(LOCK_WINS))            state_d = ST_TRACK;
        else if (win_d == WIN_W'(ACQ_TIMEOUT_WINS))  state_d = ST_CLEAR;
      end
      ST_TRACK: if (win_done) begin
        good_d = good_q + 1'b1;
        if (!win_good)                          state_d = ST_ACQ;
        else if (good_d == GOOD_W'(LOCK_WINS))  state_d = ST_LOCKED;
      end
      ST_LOCKED: if (win_done) begin
        bad_d = win_bad ? bad_q + 1'b1 : '0;
        if (bad_d == BAD_W'(LOSS_WINS)) state_d = ST_CLEAR;
      end
      ST_CLEAR: state_d = ST_ACQ;
      default:  state_d = ST_IDLE;
    endcase
    if (!bus.enable) state_d = ST_IDLE;
    if (state_d != state_q) begin
      good_d = '0;
      bad_d  = '0;
      win_d  = '0;
    end
  end

  always_comb begin
    gear = ACQ_GEAR;
    if (state_q == ST_TRACK || state_q == ST_LOCKED) gear = TRK_GEAR;
  end

  assign bus.kp_shift   = gear.kp;
  assign bus.ki_shift   = gear.ki;
  assign bus.lf_clear   = (state_q == ST_IDLE) || (state_q == ST_CLEAR);
  assign bus.locked     = (state_q == ST_LOCKED);
  assign bus.state      = state_q;
  assign bus.win_metric = win_metric;

endmodule

// File: tb/tb_cdr_loop_sequencer.sv
// Directed bench for cdr_loop_sequencer: gear shifts, lock hysteresis, timeout and enable priority.
module tb_cdr_loop_sequencer;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  cdr_loop_sequencer_if #(.WIN_LOG2(6)) bus ();

  cdr_loop_sequencer #(.WIN_LOG2(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_asserts = 0;
  int n_fail    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One strobe cycle followed by one idle cycle; returns on the negedge after the strobe edge.
  task automatic strobe(input logic signed [15:0] v);
    @(negedge clk);
    bus.sample_en = 1'b1;
    bus.f_n       = v;
    @(negedge clk);
    bus.sample_en = 1'b0;
  endtask

  task automatic strobes(input int n, input logic signed [15:0] v);
    for (int i = 0; i < n; i++) strobe(v);
  endtask

  task automatic windows(input int n, input logic signed [15:0] v);
    strobes(64 * n, v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst           = 1'b1;
    bus.enable    = 1'b0;
    bus.sample_en = 1'b0;
    bus.f_n       = '0;
    repeat (3) @(negedge clk);
    check("rst_state",    32'(bus.state),      0);
    check("rst_kp",       32'(bus.kp_shift),   8);
    check("rst_ki",       32'(bus.ki_shift),   14);
    check("rst_lf_clear", 32'(bus.lf_clear),   1);
    check("rst_locked",   32'(bus.locked),     0);
    check("rst_metric",   32'(bus.win_metric), 0);

    rst        = 1'b0;
    bus.enable = 1'b1;
    @(negedge clk);
    check("enter_acq",     32'(bus.state),    1);
    check("acq_lf_clear",  32'(bus.lf_clear), 0);

    // Four quiet windows: no advance until the 256th strobe.
    strobes(255, 16'sd0);
    check("acq_before_4th", 32'(bus.state), 1);
    strobe(16'sd0);
    check("track_state", 32'(bus.state),    2);
    check("track_kp",    32'(bus.kp_shift), 12);
    check("track_ki",    32'(bus.ki_shift), 18);

    windows(4, 16'sd0);
    check("locked_state", 32'(bus.state),  3);
    check("locked_flag",  32'(bus.locked), 1);

    // Loss of lock: two windows of 12800.
    windows(1, 16'sd200);
    check("loss_1st_state",  32'(bus.state),      3);
    check("loss_1st_metric", 32'(bus.win_metric), 12800);
    windows(1, 16'sd200);
    check("loss_clear_state", 32'(bus.state),    4);
    check("loss_clear_pulse", 32'(bus.lf_clear), 1);
    @(negedge clk);
    check("relock_state",    32'(bus.state),    1);
    check("relock_lf_clear", 32'(bus.lf_clear), 0);
    check("relock_locked",   32'(bus.locked),   0);
    check("relock_kp",       32'(bus.kp_shift), 8);
    check("relock_ki",       32'(bus.ki_shift), 14);

    // Acquisition timeout after 64 bad windows of 6400.
    windows(63, -16'sd100);
    check("timeout_63_state",  32'(bus.state),      1);
    check("timeout_63_metric", 32'(bus.win_metric), 6400);
    windows(1, -16'sd100);
    check("timeout_clear", 32'(bus.state),    4);
    check("timeout_lfclr", 32'(bus.lf_clear), 1);
    @(negedge clk);
    check("timeout_back_acq", 32'(bus.state), 1);

    for (int i = 0; i < 4; i++) begin
      windows(1, 16'sd0);
      windows(1, -16'sd100);
    end
    check("alternate_stays_acq", 32'(bus.state), 1);

    windows(1, -16'sd32768);
    check("max_metric", 32'(bus.win_metric), 2097152);

    // Sum exactly LOCK_THR is bad: three good windows then 2048 must not advance.
    windows(3, 16'sd0);
    windows(1, 16'sd32);
    check("thr_2048_metric", 32'(bus.win_metric), 2048);
    check("thr_2048_bad",    32'(bus.state),      1);
    windows(3, 16'sd0);
    strobes(63, 16'sd32);
    strobe(16'sd31);
    check("thr_2047_metric", 32'(bus.win_metric), 2047);
    check("thr_2047_good",   32'(bus.state),      2);

    windows(1, -16'sd100);
    check("track_bad_to_acq", 32'(bus.state),    1);
    check("track_bad_noclr",  32'(bus.lf_clear), 0);

    windows(8, 16'sd0);
    check("relocked", 32'(bus.state), 3);

    // Sum exactly UNLOCK_THR is not bad; 4097 is, and a non-bad window resets the count.
    windows(2, 16'sd64);
    check("unlock_4096_metric", 32'(bus.win_metric), 4096);
    check("unlock_4096_ok",     32'(bus.state),      3);
    strobes(63, 16'sd64);
    strobe(16'sd65);
    check("unlock_4097_metric", 32'(bus.win_metric), 4097);
    check("unlock_4097_once",   32'(bus.state),      3);
    windows(1, 16'sd64);
    strobes(63, 16'sd64);
    strobe(16'sd65);
    check("bad_cnt_reset", 32'(bus.state), 3);
    strobes(63, 16'sd64);
    strobe(16'sd65);
    check("bad_twice_clear", 32'(bus.state), 4);
    @(negedge clk);
    check("bad_twice_acq", 32'(bus.state), 1);

    // Enable drop mid-window, then a fresh window on re-enable.
    strobes(10, 16'sd0);
    @(negedge clk);
    bus.enable = 1'b0;
    @(negedge clk);
    check("disable_idle",  32'(bus.state),    0);
    check("disable_lfclr", 32'(bus.lf_clear), 1);
    bus.enable = 1'b1;
    @(negedge clk);
    check("reenable_acq", 32'(bus.state), 1);
    strobes(63, 16'sd100);
    check("fresh_window_open",  32'(bus.win_metric), 4097);
    strobe(16'sd100);
    check("fresh_window_close", 32'(bus.win_metric), 6400);

    // Enable drop on the strobe that would otherwise advance to TRACK.
    windows(3, 16'sd0);
    strobes(63, 16'sd0);
    @(negedge clk);
    bus.sample_en = 1'b1;
    bus.f_n       = 16'sd0;
    bus.enable    = 1'b0;
    @(negedge clk);
    bus.sample_en = 1'b0;
    check("disable_priority", 32'(bus.state),    0);
    check("disable_prio_kp",  32'(bus.kp_shift), 8);
    bus.enable = 1'b1;
    @(negedge clk);
    check("reenable_acq_2", 32'(bus.state), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
